uart_frame_check: RTL and testbench
===================================

# uart_frame_check

Parametrised UART receive frame checker, the successor to the single-bit stop checker in the RX path. It sits between the RX bit sampler and the RX-to-APB data FIFO. It consumes one sampled bit per bit period and assembles the data word. It checks optional parity and one or two stop bits, and reports each frame with per-frame error flags and saturating error counters that APB software reads.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (5..9), received LSB first
- CNT_W, 8, width of each saturating error counter

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; start bit confirmed by the sampler
- bit_vld  in  1  one-cycle strobe; samp_out holds the mid-bit sample
- samp_out  in  1  sampled line value
- par_en  in  1  parity bit present; latched at frame_start
- par_odd  in  1  1 = odd parity, 0 = even; latched at frame_start
- two_stop  in  1  1 = two stop bits; latched at frame_start
- cnt_clr  in  1  clears both error counters
- busy  out  1  frame in progress
- data_out  out  DATA_W  assembled data word, held until the next frame_vld
- frame_vld  out  1  one-cycle pulse; frame complete
- par_err  out  1  parity mismatch for the reported frame; valid with frame_vld
- stop_err  out  1  stop bit sampled 0; valid with frame_vld
- par_err_cnt  out  CNT_W  saturating parity error count
- stop_err_cnt  out  CNT_W  saturating framing error count

## Operation
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE: bit_vld is ignored. frame_start latches the config, clears the shift register and bit counter, and moves to DATA.
- DATA: each bit_vld shifts samp_out in at the MSB side, so the first bit received lands at bit 0. The running XOR parity is updated on each bit. After DATA_W bits the FSM goes to PARITY if par_en is set, else to STOP1.
- PARITY: on bit_vld, the parity error is computed as (xor_data ^ samp_out ^ par_odd) != 0 and stored. The FSM then goes to STOP1.
- STOP1: on bit_vld, if samp_out is 0 the frame ends with stop_err = 1. If samp_out is 1 and two_stop is set, the FSM goes to STOP2. Otherwise the frame ends with stop_err = 0.
- STOP2: on bit_vld, the frame ends with stop_err = !samp_out.
- Frame end: the FSM returns to IDLE. data_out, par_err and stop_err are registered, and frame_vld pulses.
- Abort: frame_start while busy discards the current frame with no frame_vld, then restarts in DATA with the newly latched config.
- frame_start and bit_vld in the same cycle: frame_start wins and that bit is ignored.
- Counters: each counter increments by 1 on a frame_vld that carries its error, and saturates at 2^CNT_W-1. cnt_clr has priority over an increment in the same cycle, and the result is 0.
- par_err is always 0 for frames received with par_en = 0.
- Reset values: state IDLE; busy 0, frame_vld 0, par_err 0, stop_err 0; data_out 0; both counters 0. Reset mid-frame discards the frame and produces no frame_vld.

## Timing
- frame_vld, data_out, par_err and stop_err are registered. They appear exactly 1 cycle after the clock edge that samples the final stop bit (STOP1 with an error or single stop, or STOP2).
- Counters update in the same cycle frame_vld is high, so the new value is visible the cycle after.
- busy goes high the cycle after frame_start and low the same cycle frame_vld is high.
- bit_vld strobes arrive at least 2 cycles apart. There is no backpressure, and the consumer must accept frame_vld unconditionally.
- Config inputs are sampled only at frame_start. Changes mid-frame have no effect.

## Structure
- Shared package uart_pkg holds the FSM state encoding (uart_fc_state_t) and the DATA_W range limits, shared with the sampler and TX framer.
- One sub-module is natural: uart_sat_cnt, parameterised by CNT_W, with inc, clr and count ports. It is instantiated twice, once per error counter.
- Parity uses a running XOR in the top level. No separate module is needed.

## Test plan
- DATA_W=8, par_en=0, 1 stop; bits 1,0,1,0,0,1,0,1 then stop 1 -> data_out=0xA5, frame_vld pulses 1 cycle after the stop strobe, par_err=0, stop_err=0, counters remain 0.
- par_en=1, par_odd=0, data 0xA5, parity bit 1 -> par_err=1, par_err_cnt=1. Repeat with parity bit 0 -> par_err=0, par_err_cnt stays 1.
- two_stop=1, data 0x3C, stop bits 1 then 0 -> stop_err=1 after STOP2, stop_err_cnt=1. Stop bits 0 -> frame ends after STOP1 with stop_err=1, and a further bit_vld in IDLE is ignored.
- frame_start after 3 data bits, then a full 0x5A frame -> a single frame_vld with data_out=0x5A and no report for the aborted frame. frame_start coincident with bit_vld -> that bit is not shifted in.
- CNT_W=2, five frames with stop_err -> stop_err_cnt=3 (saturated). cnt_clr coincident with a sixth error -> count 0.
- rst asserted mid-DATA for 1 cycle -> busy=0, no frame_vld. The next full frame 0xFF decodes correctly with counters at 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-checker state encoding, data-width limits and
// the parity helper used by the RX path.
package uart_pkg;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    typedef logic [2:0] uart_fc_state_t;

    localparam uart_fc_state_t ST_IDLE   = 3'd0;
    localparam uart_fc_state_t ST_DATA   = 3'd1;
    localparam uart_fc_state_t ST_PARITY = 3'd2;
    localparam uart_fc_state_t ST_STOP1  = 3'd3;
    localparam uart_fc_state_t ST_STOP2  = 3'd4;

    // 1 when the received parity bit disagrees with the selected polarity
    function automatic logic par_mismatch(input logic xor_data, input logic par_bit,
                                          input logic odd);
        return xor_data ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating up-counter for UART error statistics; clear beats increment.
module uart_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count up on inc, hold at all-ones, clear on clr
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/uart_frame_check.sv
// UART RX frame checker: assembles DATA_W data bits, checks optional parity and
// one or two stop bits, and reports each frame with error flags and counters.
module uart_frame_check
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              bit_vld,
    input  logic              samp_out,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              two_stop,
    input  logic              cnt_clr,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_vld,
    output logic              par_err,
    output logic              stop_err,
    output logic [CNT_W-1:0]  par_err_cnt,
    output logic [CNT_W-1:0]  stop_err_cnt
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    uart_fc_state_t    state_r;
    uart_fc_state_t    state_nxt_s;
    logic [DATA_W-1:0] shift_r;
    logic [BC_W-1:0]   bit_cnt_r;
    logic              xor_r;
    logic              par_en_r;
    logic              par_odd_r;
    logic              two_stop_r;
    logic              par_err_pend_r;
    logic              end_s;
    logic              end_stop_err_s;
    logic              busy_r;
    logic              frame_vld_r;
    logic [DATA_W-1:0] data_out_r;
    logic              par_err_r;
    logic              stop_err_r;

    // Next state and frame-end detection; frame_start overrides any strobe
    always_comb begin
        state_nxt_s    = state_r;
        end_s          = 1'b0;
        end_stop_err_s = 1'b0;
        if (frame_start) begin
            state_nxt_s = ST_DATA;
        end else if (bit_vld) begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_DATA: begin
                    if (bit_cnt_r == BC_LAST) begin
                        state_nxt_s = par_en_r ? ST_PARITY : ST_STOP1;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    state_nxt_s = ST_STOP1;
                end
                ST_STOP1: begin
                    if (!samp_out) begin
                        end_s          = 1'b1;
                        end_stop_err_s = 1'b1;
                        state_nxt_s    = ST_IDLE;
                    end else if (two_stop_r) begin
                        state_nxt_s = ST_STOP2;
                    end else begin
                        end_s       = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_STOP2: begin
                    end_s          = 1'b1;
                    end_stop_err_s = !samp_out;
                    state_nxt_s    = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else if (state_r > ST_STOP2) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Config latch, bit assembly, running parity and registered frame report
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            shift_r        <= {DATA_W{1'b0}};
            bit_cnt_r      <= {BC_W{1'b0}};
            xor_r          <= 1'b0;
            par_en_r       <= 1'b0;
            par_odd_r      <= 1'b0;
            two_stop_r     <= 1'b0;
            par_err_pend_r <= 1'b0;
            busy_r         <= 1'b0;
            frame_vld_r    <= 1'b0;
            data_out_r     <= {DATA_W{1'b0}};
            par_err_r      <= 1'b0;
            stop_err_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            frame_vld_r <= end_s;
            if (frame_start) begin
                par_en_r       <= par_en;
                par_odd_r      <= par_odd;
                two_stop_r     <= two_stop;
                shift_r        <= {DATA_W{1'b0}};
                bit_cnt_r      <= {BC_W{1'b0}};
                xor_r          <= 1'b0;
                par_err_pend_r <= 1'b0;
            end else if (bit_vld && (state_r == ST_DATA)) begin
                // First bit received ends up at bit 0 after DATA_W shifts
                shift_r   <= {samp_out, shift_r[DATA_W-1:1]};
                bit_cnt_r <= bit_cnt_r + BC_W'(1);
                xor_r     <= xor_r ^ samp_out;
            end else if (bit_vld && (state_r == ST_PARITY)) begin
                par_err_pend_r <= par_mismatch(xor_r, samp_out, par_odd_r);
            end
            if (end_s) begin
                data_out_r <= shift_r;
                par_err_r  <= par_en_r & par_err_pend_r;
                stop_err_r <= end_stop_err_s;
            end
        end
    end

    uart_sat_cnt #(.CNT_W(CNT_W)) u_par_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_vld_r & par_err_r),
        .clr   (cnt_clr),
        .count (par_err_cnt)
    );

    uart_sat_cnt #(.CNT_W(CNT_W)) u_stop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_vld_r & stop_err_r),
        .clr   (cnt_clr),
        .count (stop_err_cnt)
    );

    assign busy      = busy_r;
    assign frame_vld = frame_vld_r;
    assign data_out  = data_out_r;
    assign par_err   = par_err_r;
    assign stop_err  = stop_err_r;

endmodule

// File: tb/tb_uart_frame_check.sv
// Randomised self-checking bench for uart_frame_check against a frame-level model.
module tb_uart_frame_check;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, frame_start, bit_vld, samp_out, par_en, par_odd, two_stop, cnt_clr;
    logic busy, frame_vld, par_err, stop_err;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  par_err_cnt, stop_err_cnt;

    int checks = 0;
    int errors = 0;
    int vld_seen = 0;
    int exp_vld = 0;
    int exp_par_cnt = 0;
    int exp_stop_cnt = 0;
    logic [DATA_W-1:0] last_data = '0;

    uart_frame_check #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .bit_vld      (bit_vld),
        .samp_out     (samp_out),
        .par_en       (par_en),
        .par_odd      (par_odd),
        .two_stop     (two_stop),
        .cnt_clr      (cnt_clr),
        .busy         (busy),
        .data_out     (data_out),
        .frame_vld    (frame_vld),
        .par_err      (par_err),
        .stop_err     (stop_err),
        .par_err_cnt  (par_err_cnt),
        .stop_err_cnt (stop_err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_vld === 1'b1) vld_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic b);
        bit_vld  = 1'b1;
        samp_out = b;
        tick();
        bit_vld  = 1'b0;
        samp_out = 1'($urandom);
    endtask

    task automatic start_frame(input logic pe, input logic po, input logic ts,
                               input logic coincide, input logic csamp);
        frame_start = 1'b1;
        par_en      = pe;
        par_odd     = po;
        two_stop    = ts;
        bit_vld     = coincide;
        samp_out    = csamp;
        tick();
        frame_start = 1'b0;
        bit_vld     = 1'b0;
        // Config changes mid-frame must be ignored
        par_en      = 1'($urandom);
        par_odd     = 1'($urandom);
        two_stop    = 1'($urandom);
        chk("busy_start", 32'(busy), 32'd1);
        chk("data_hold", 32'(data_out), 32'(last_data));
    endtask

    // Drives one complete frame and checks the report against the frame rules
    task automatic run_frame(input logic [DATA_W-1:0] data, input logic pe, input logic po,
                             input logic ts, input logic pbit, input logic s1, input logic s2,
                             input logic coincide, input logic clr);
        logic exp_pe, exp_se;
        exp_pe = pe && (((^data) ^ pbit ^ po) != 1'b0);
        exp_se = !s1 || (ts && !s2);
        start_frame(pe, po, ts, coincide, ~data[0]);
        idle(1);
        for (int i = 0; i < DATA_W; i++) begin
            strobe(data[i]);
            idle($urandom_range(1, 2));
        end
        if (pe) begin
            strobe(pbit);
            idle($urandom_range(1, 2));
        end
        if (s1 && ts) begin
            strobe(s1);
            idle($urandom_range(1, 2));
            chk("busy_mid", 32'(busy), 32'd1);
            strobe(s2);
        end else begin
            strobe(s1);
        end
        exp_vld++;
        chk("frame_vld", 32'(frame_vld), 32'd1);
        chk("data_out", 32'(data_out), 32'(data));
        chk("par_err", 32'(par_err), 32'(exp_pe));
        chk("stop_err", 32'(stop_err), 32'(exp_se));
        chk("busy_end", 32'(busy), 32'd0);
        last_data = data;
        cnt_clr = clr;
        tick();
        cnt_clr = 1'b0;
        if (clr) begin
            exp_par_cnt  = 0;
            exp_stop_cnt = 0;
        end else begin
            if (exp_pe && exp_par_cnt < CNT_MAX) exp_par_cnt++;
            if (exp_se && exp_stop_cnt < CNT_MAX) exp_stop_cnt++;
        end
        chk("vld_pulse", 32'(frame_vld), 32'd0);
        chk("par_cnt", 32'(par_err_cnt), 32'(exp_par_cnt));
        chk("stop_cnt", 32'(stop_err_cnt), 32'(exp_stop_cnt));
        chk("vld_count", 32'(vld_seen), 32'(exp_vld));
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; bit_vld = 1'b0; samp_out = 1'b1;
        par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0; cnt_clr = 1'b0;
        idle(3);
        rst = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(frame_vld), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_stop_err", 32'(stop_err), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_par_cnt", 32'(par_err_cnt), 32'd0);
        chk("rst_stop_cnt", 32'(stop_err_cnt), 32'd0);

        // Plain 8N1, then even parity wrong and right
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // Two stop bits: second bad, then first bad ends early
        run_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Strobes while idle are ignored
        strobe(1'b0);
        idle(2);
        strobe(1'b1);
        idle(2);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_vld", 32'(vld_seen), 32'(exp_vld));

        // Abort after 3 data bits, then a full frame
        start_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            strobe(1'($urandom));
            idle(1);
        end
        run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // frame_start coincident with a strobe
        run_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Saturation of the 2-bit stop counter, then clear against an error
        for (int i = 0; i < 5; i++)
            run_frame(8'(i * 37), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stop_sat", 32'(stop_err_cnt), 32'd3);
        run_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stop_clr", 32'(stop_err_cnt), 32'd0);

        // Reset in the middle of DATA
        start_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1);
            idle(1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_par_cnt = 0;
        exp_stop_cnt = 0;
        last_data = '0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        idle(3);
        chk("mid_rst_vld", 32'(vld_seen), 32'(exp_vld));
        run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Random frames
        for (int n = 0; n < 40; n++) begin
            run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
